// File: rtl/dup_demux_buf_if.sv
// Handshake bundle for dup_demux_buf.
//   Producer side: in_data, in_s, in_valid -> ; <- in_ready
//   Destination A: <- a_data, a_valid, a_count ; a_ready ->
//   Destination B: <- b_data, b_valid, b_count ; b_ready ->
// master: the environment (producer + both consumers).
// slave : the demultiplexer itself.
interface dup_demux_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  modport master (
    output in_data, in_s, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

  modport slave (
    input  in_data, in_s, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );
endinterface

// File: rtl/dup_demux_buf.sv
// Buffered 1-to-2 demultiplexer. Each producer beat is steered by in_s to
// destination A (0) or B (1); every destination owns a DEPTH-entry FIFO so
// back-pressure on one side never disturbs the other.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears pointers/counts, not storage)
//   bus   - dup_demux_buf_if.slave: producer handshake, A/B outputs, counts
module dup_demux_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  dup_demux_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 is destination A, index 1 is destination B.
  logic [WIDTH-1:0] mem  [2][DEPTH];
  logic [PW-1:0]    wptr [2];
  logic [PW-1:0]    rptr [2];
  logic [CW-1:0]    cnt  [2];

  logic [1:0] sel;
  logic [1:0] rdy;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] nonempty;
  logic       in_ready_i;

  // in_ready depends only on registered counts and in_s: no path from
  // the consumer readies, so a same-cycle pop never frees a full FIFO.
  always_comb begin
    sel        = {bus.in_s, ~bus.in_s};
    rdy        = {bus.b_ready, bus.a_ready};
    in_ready_i = bus.in_s ? (cnt[1] != FULL) : (cnt[0] != FULL);
    nonempty   = '0;
    push       = '0;
    pop        = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      nonempty[i] = (cnt[i] != '0);
      push[i]     = bus.in_valid && in_ready_i && sel[i];
      pop[i]      = nonempty[i] && rdy[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wptr[i]] <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready_i;
  assign bus.a_data   = mem[0][rptr[0]];
  assign bus.b_data   = mem[1][rptr[1]];
  assign bus.a_valid  = nonempty[0];
  assign bus.b_valid  = nonempty[1];
  assign bus.a_count  = cnt[0];
  assign bus.b_count  = cnt[1];
endmodule

// File: tb/tb_dup_demux_buf.sv
// Self-checking bench for dup_demux_buf: a table of directed vectors, hand
// sequences for the multi-cycle corners, and randomized traffic, all checked
// against a queue-based reference model of the two destinations.
module tb_dup_demux_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dup_demux_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  dup_demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: one queue per destination, head at index 0.
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] rxb [$];

  typedef struct {
    logic [31:0] d;
    logic        s, v, ar, br;
    logic        rdy;
    int          ac, bc;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic s, input logic v,
                       input logic ar, input logic br);
    bus.in_data  = d;
    bus.in_s     = s;
    bus.in_valid = v;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  function automatic logic exp_rdy();
    return bus.in_s ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
  endfunction

  task automatic check_model();
    chk("in_ready", bus.in_ready, exp_rdy());
    chk("a_valid", bus.a_valid, qa.size() != 0);
    chk("b_valid", bus.b_valid, qb.size() != 0);
    chk("a_count", bus.a_count, qa.size());
    chk("b_count", bus.b_count, qb.size());
    if (qa.size() != 0) chk("a_data", bus.a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", bus.b_data, qb[0]);
  endtask

  // Advance one clock, applying the model's view of the handshakes.
  task automatic step();
    logic acc, pa, pb, s;
    logic [31:0] d;
    acc = bus.in_valid && exp_rdy();
    pa  = (qa.size() != 0) && bus.a_ready;
    pb  = (qb.size() != 0) && bus.b_ready;
    d   = bus.in_data;
    s   = bus.in_s;
    if (pb) rxb.push_back(bus.b_data);
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
    #1;
  endtask

  task automatic cyc(input logic [31:0] d, input logic s, input logic v,
                     input logic ar, input logic br);
    drive(d, s, v, ar, br);
    #4;
    check_model();
    step();
  endtask

  initial begin
    int sent;
    logic v;

    // Back-pressure scenario on A, with one beat routed to B meanwhile.
    tbl[0] = '{32'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[1] = '{32'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
    tbl[2] = '{32'hA2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0};
    tbl[3] = '{32'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 0};
    tbl[4] = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    tbl[5] = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1};
    tbl[6] = '{32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1};
    tbl[7] = '{32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};

    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check_model();
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].ar, tbl[i].br);
      #4;
      chk("tbl_in_ready", bus.in_ready, tbl[i].rdy);
      chk("tbl_a_count", bus.a_count, tbl[i].ac);
      chk("tbl_b_count", bus.b_count, tbl[i].bc);
      if (i == 4) chk("tbl_a_head0", bus.a_data, 32'hA0);
      if (i == 5) chk("tbl_a_head1", bus.a_data, 32'hA1);
      if (i == 6) chk("tbl_b_head", bus.b_data, 32'hB0);
      check_model();
      step();
    end

    // Routing with both consumers ready.
    cyc(32'h11111111, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(32'h22222222, 1'b1, 1'b1, 1'b1, 1'b1);
    #4;
    chk("route_a_valid", bus.a_valid, 1'b1);
    chk("route_a_data", bus.a_data, 32'h11111111);
    check_model();
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #4;
    chk("route_b_data", bus.b_data, 32'h22222222);
    chk("route_a_once", bus.a_valid, 1'b0);
    check_model();
    step();
    cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Simultaneous push/pop on A with one beat resident.
    cyc(32'hC0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      drive(32'hC1 + 32'(k), 1'b0, 1'b1, 1'b1, 1'b1);
      #4;
      chk("pp_a_count", bus.a_count, 1);
      chk("pp_a_data", bus.a_data, 32'hC0 + 32'(k));
      check_model();
      step();
    end
    cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Wrap-around on B with random consumer readiness.
    rxb.delete();
    sent = 0;
    for (int c = 0; c < 300 && (sent < 10 || qb.size() != 0); c++) begin
      v = (sent < 10);
      drive(32'(sent), 1'b1, v, 1'b0, 1'($urandom_range(0, 1)));
      #4;
      check_model();
      if (v && exp_rdy()) sent++;
      step();
    end
    chk("wrap_sent", sent, 10);
    chk("wrap_count", rxb.size(), 10);
    for (int i = 0; i < 10 && i < rxb.size(); i++) chk("wrap_order", rxb[i], 32'(i));

    // Full refuses input even with a same-cycle pop.
    cyc(32'hD0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(32'hD1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'hD2, 1'b0, 1'b1, 1'b1, 1'b0);
    #4;
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_a_count", bus.a_count, 2);
    check_model();
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    chk("full_pop_count", bus.a_count, 1);
    chk("full_pop_head", bus.a_data, 32'hD1);
    check_model();
    step();

    // Asynchronous reset mid-stream with A holding two beats.
    cyc(32'hD3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_a_count", bus.a_count, 2);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", bus.a_valid, 1'b0);
    chk("rst_a_count", bus.a_count, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_b_valid", bus.b_valid, 1'b0);
    qa.delete();
    qb.delete();
    #2;
    check_model();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(32'hE0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #4;
    chk("post_rst_a_data", bus.a_data, 32'hE0);
    check_model();
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++)
      cyc($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 2 * DEPTH; c++) cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("drain_a_count", bus.a_count, 0);
    chk("drain_b_count", bus.b_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
